// File: rtl/pipe_stall_ctrl.sv
// Pipeline freeze/flush sequencer: merges SRAM wait-states, ID hazards and
// EXE branch flushes into per-stage freeze, flush and bubble controls.
// A branch that lands during an SRAM stall is held and replayed when the
// stall ends, so the flush is never lost.
module pipe_stall_ctrl #(
  parameter int unsigned SRAM_WAIT = 5,
  parameter int unsigned CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_r_en,
  input  logic mem_w_en,
  input  logic hazard,
  input  logic branch_taken,
  output logic freeze_if,
  output logic freeze_id,
  output logic freeze_exe,
  output logic freeze_mem,
  output logic flush,
  output logic bubble,
  output logic sram_ready,
  output logic sram_busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_WAIT - 1);
  localparam bit               SINGLE   = (SRAM_WAIT == 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_flush;

  logic w_mem_req;
  logic w_ready;
  logic w_stall;
  logic w_flush;

  // Stall/flush decode; everything is held low while reset is asserted
  always_comb begin
    w_mem_req = mem_r_en | mem_w_en;
    w_ready   = 1'b0;
    if (rst && w_mem_req) begin
      if (r_state == S_IDLE) w_ready = SINGLE;
      else                   w_ready = (r_cnt == LAST_CNT);
    end
    w_stall = rst & w_mem_req & ~w_ready;
    w_flush = rst & ~w_stall & (branch_taken | r_pend_flush);

    freeze_id  = w_stall;
    freeze_exe = w_stall;
    freeze_mem = w_stall;
    // Flush beats hazard: the hazarding instruction is being discarded anyway
    freeze_if  = w_stall | (rst & hazard & ~w_flush);
    flush      = w_flush;
    bubble     = rst & hazard & ~w_stall & ~w_flush;
    sram_ready = w_ready;
    sram_busy  = rst & (r_state == S_ACCESS);
  end

  // SRAM access sequencer: counts wait-states, aborts if the request drops
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_req && !SINGLE) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!w_mem_req || w_ready) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Remember a branch that arrived while stalled; drop it once flushed
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_flush <= 1'b0;
    end else if (branch_taken && w_stall) begin
      r_pend_flush <= 1'b1;
    end else if (w_flush) begin
      r_pend_flush <= 1'b0;
    end
  end

endmodule
